// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA-style raster timing generator.
// Free-running horizontal/vertical counters advance on each pix_en tick.
// Sync, blanking, colour and frame-start outputs are registered from the
// pre-increment counters, so they trail pixel_x/pixel_y by one tick.
// Optional feature macro: VGA_TEST_PATTERN_EN. When it is defined,
// pattern_sel=1 replaces the active-area colour with eight vertical bars.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int COLOR_W  = 1,
  parameter int CNT_W    = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 pix_en,
  input  logic [3*COLOR_W-1:0] rgb_in,
  input  logic                 pattern_sel,
  output logic [CNT_W-1:0]     pixel_x,
  output logic [CNT_W-1:0]     pixel_y,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 video_on,
  output logic [3*COLOR_W-1:0] rgb_out,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Counter-width versions of the decode points.
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SYNC_S = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SYNC_E = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CNT_W-1:0] V_SYNC_S = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SYNC_E = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Counter state.
  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;

  // Registered outputs.
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic                 video_on_q, video_on_d;
  logic [3*COLOR_W-1:0] rgb_out_q, rgb_out_d;
  logic                 frame_start_q, frame_start_d;

  // Decoded from the current (pre-increment) counters.
  logic                 h_in_sync;
  logic                 v_in_sync;
  logic                 in_active;
  logic                 at_origin;
  logic [3*COLOR_W-1:0] pix_color;

`ifdef VGA_TEST_PATTERN_EN
  // Bar width in pixels; the last bar absorbs any remainder of H_ACTIVE/8.
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0]           bar_idx;
  logic [3*COLOR_W-1:0] bar_rgb;

  // Bar index by threshold comparison against constant bar boundaries.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h_cnt_q) >= k * BAR_W) begin
        bar_idx = 3'(k);
      end
    end
    bar_rgb = {{COLOR_W{bar_idx[2]}}, {COLOR_W{bar_idx[1]}}, {COLOR_W{bar_idx[0]}}};
  end

  assign pix_color = pattern_sel ? bar_rgb : rgb_in;
`else
  // pattern_sel has no function in this build; tie it off explicitly.
  logic pattern_sel_unused;
  assign pattern_sel_unused = pattern_sel;
  assign pix_color          = rgb_in;
`endif

  // Region decode for the pixel currently addressed by the counters.
  always_comb begin
    h_in_sync = (h_cnt_q >= H_SYNC_S) && (h_cnt_q <= H_SYNC_E);
    v_in_sync = (v_cnt_q >= V_SYNC_S) && (v_cnt_q <= V_SYNC_E);
    in_active = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  // Next-state for counters: horizontal wraps at line end and carries into vertical.
  always_comb begin
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    if (pix_en) begin
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        if (v_cnt_q == V_LAST) begin
          v_cnt_d = '0;
        end else begin
          v_cnt_d = v_cnt_q + CNT_ONE;
        end
      end else begin
        h_cnt_d = h_cnt_q + CNT_ONE;
      end
    end
  end

  // Next-state for outputs: capture decoded values on a tick, hold otherwise.
  always_comb begin
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    rgb_out_d     = rgb_out_q;
    frame_start_d = frame_start_q;
    if (pix_en) begin
      hsync_d       = h_in_sync ? HS_POL : ~HS_POL;
      vsync_d       = v_in_sync ? VS_POL : ~VS_POL;
      video_on_d    = in_active;
      rgb_out_d     = in_active ? pix_color : '0;
      frame_start_d = at_origin;
    end
  end

  // State registers with synchronous active-low reset; syncs idle at their inactive level.
  always_ff @(posedge clk) begin
    if (!rst) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      video_on_q    <= 1'b0;
      rgb_out_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      rgb_out_q     <= rgb_out_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = h_cnt_q;
  assign pixel_y     = v_cnt_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb_out     = rgb_out_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench for vga_timing_gen.
// Instance A uses default (640x480) timing; instance B uses a tiny raster
// (24x15, active-high hsync, 5-bit counters) so whole frames fit in a short run.
// Stimulus pushes hand-computed expectations tagged with an absolute cycle;
// the monitor pops and compares them on the falling edge of that cycle.
module tb_vga_timing_gen;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pix_en = 1'b0;
  logic [2:0] rgb_in = 3'b000;
  logic       pattern_sel = 1'b0;

  logic [10:0] a_x, a_y;
  logic        a_hs, a_vs, a_von, a_fs;
  logic [2:0]  a_rgb;
  logic [4:0]  b_x, b_y;
  logic        b_hs, b_vs, b_von, b_fs;
  logic [2:0]  b_rgb;

  vga_timing_gen dut_a (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
    .pixel_x(a_x), .pixel_y(a_y), .hsync(a_hs), .vsync(a_vs), .video_on(a_von),
    .rgb_out(a_rgb), .frame_start(a_fs)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .HS_POL(1'b1), .VS_POL(1'b0), .COLOR_W(1), .CNT_W(5)
  ) dut_b (
    .clk(clk), .rst(rst), .pix_en(pix_en), .rgb_in(rgb_in), .pattern_sel(pattern_sel),
    .pixel_x(b_x), .pixel_y(b_y), .hsync(b_hs), .vsync(b_vs), .video_on(b_von),
    .rgb_out(b_rgb), .frame_start(b_fs)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {
    S_CLR, A_X, A_Y, A_HS, A_VS, A_VON, A_RGB, A_FS,
    B_X, B_Y, B_HS, B_VS, B_VON, B_RGB, B_FS,
    CA_HSLO, CA_RGB, CA_FS, CB_VSLO, CB_HSHI, CB_RGB, CB_FS
  } sel_e;

  typedef struct {
    int   cyc;
    sel_e sel;
    int   val;
  } exp_t;

  exp_t sbq[$];
  int   base = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  // Window counters, cleared by S_CLR and after each count comparison.
  int ca_hslo = 0, ca_rgb = 0, ca_fs = 0;
  int cb_vslo = 0, cb_hshi = 0, cb_rgb = 0, cb_fs = 0;

  task automatic push(input int n, input sel_e s, input int v);
    exp_t e;
    int   i;
    e.cyc = base + n;
    e.sel = s;
    e.val = v;
    i = sbq.size();
    while (i > 0 && sbq[i-1].cyc > e.cyc) i--;
    sbq.insert(i, e);
  endtask

  function automatic int actual(input sel_e s);
    case (s)
      A_X:     return int'(a_x);
      A_Y:     return int'(a_y);
      A_HS:    return int'(a_hs);
      A_VS:    return int'(a_vs);
      A_VON:   return int'(a_von);
      A_RGB:   return int'(a_rgb);
      A_FS:    return int'(a_fs);
      B_X:     return int'(b_x);
      B_Y:     return int'(b_y);
      B_HS:    return int'(b_hs);
      B_VS:    return int'(b_vs);
      B_VON:   return int'(b_von);
      B_RGB:   return int'(b_rgb);
      B_FS:    return int'(b_fs);
      CA_HSLO: return ca_hslo;
      CA_RGB:  return ca_rgb;
      CA_FS:   return ca_fs;
      CB_VSLO: return cb_vslo;
      CB_HSHI: return cb_hshi;
      CB_RGB:  return cb_rgb;
      CB_FS:   return cb_fs;
      default: return -1;
    endcase
  endfunction

  // Monitor: accumulate window counts, then pop every expectation due this cycle.
  exp_t me;
  int   mact;
  always @(negedge clk) begin
    if (a_hs == 1'b0)     ca_hslo++;
    if (a_rgb == 3'b101)  ca_rgb++;
    if (a_fs == 1'b1)     ca_fs++;
    if (b_vs == 1'b0)     cb_vslo++;
    if (b_hs == 1'b1)     cb_hshi++;
    if (b_rgb == 3'b101)  cb_rgb++;
    if (b_fs == 1'b1)     cb_fs++;
    while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
      me = sbq.pop_front();
      if (me.sel == S_CLR) begin
        ca_hslo = 0; ca_rgb = 0; ca_fs = 0;
        cb_vslo = 0; cb_hshi = 0; cb_rgb = 0; cb_fs = 0;
      end else begin
        n_checks++;
        mact = actual(me.sel);
        if (me.cyc != cyc) begin
          n_fail++;
          $display("FAIL %s: expectation for cycle %0d missed (now %0d), required %0d",
                   me.sel.name(), me.cyc, cyc, me.val);
        end else if (mact != me.val) begin
          n_fail++;
          $display("FAIL %s at cycle %0d (offset %0d): got %0d, required %0d",
                   me.sel.name(), cyc, cyc - base, mact, me.val);
        end
        case (me.sel)
          CA_HSLO: ca_hslo = 0;
          CA_RGB:  ca_rgb  = 0;
          CA_FS:   ca_fs   = 0;
          CB_VSLO: cb_vslo = 0;
          CB_HSHI: cb_hshi = 0;
          CB_RGB:  cb_rgb  = 0;
          CB_FS:   cb_fs   = 0;
          default: ;
        endcase
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for 'cycles' edges and expect the reset state after the last one.
  task automatic do_reset(input int cycles, input logic en);
    rst    = 1'b0;
    pix_en = en;
    base   = cyc;
    push(cycles, A_X, 0);   push(cycles, A_Y, 0);
    push(cycles, A_HS, 1);  push(cycles, A_VS, 1);
    push(cycles, A_VON, 0); push(cycles, A_RGB, 0);
    push(cycles, A_FS, 0);
    push(cycles, B_X, 0);   push(cycles, B_Y, 0);
    push(cycles, B_HS, 0);  push(cycles, B_VS, 1);
    repeat (cycles) tick();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    tick();

    // Continuous ticks, constant colour 101: line/frame timing on both rasters.
    rgb_in = 3'b101; pattern_sel = 1'b0;
    do_reset(2, 1'b1);
    rst = 1'b1; pix_en = 1'b1; base = cyc;
    push(0, S_CLR, 0);
    push(1, A_FS, 1);   push(1, A_X, 1);    push(1, A_Y, 0);   push(1, A_VON, 1);
    push(1, A_RGB, 5);  push(1, A_HS, 1);   push(1, A_VS, 1);  push(2, A_FS, 0);
    push(640, A_X, 640); push(640, A_VON, 1); push(640, A_RGB, 5);
    push(641, A_VON, 0); push(641, A_RGB, 0);
    push(656, A_HS, 1); push(657, A_HS, 0); push(752, A_HS, 0); push(753, A_HS, 1);
    push(799, A_X, 799); push(799, A_Y, 0); push(800, A_X, 0); push(800, A_Y, 1);
    push(800, CA_HSLO, 96); push(800, CA_RGB, 640); push(800, CA_FS, 1);
    push(1600, CA_HSLO, 96); push(1600, CA_RGB, 640); push(1600, CA_FS, 0);
    push(1600, A_X, 0); push(1600, A_Y, 2);
    push(1, B_FS, 1);   push(1, B_X, 1);    push(1, B_Y, 0);   push(1, B_HS, 0);
    push(1, B_VS, 1);   push(1, B_VON, 1);  push(1, B_RGB, 5);
    push(18, B_HS, 0);  push(19, B_HS, 1);  push(21, B_HS, 1); push(22, B_HS, 0);
    push(176, B_VON, 1); push(192, B_VON, 0); push(193, B_VON, 0); push(193, B_RGB, 0);
    push(240, B_VS, 1); push(241, B_VS, 0); push(288, B_VS, 0); push(289, B_VS, 1);
    push(359, B_X, 23); push(359, B_Y, 14); push(360, B_X, 0); push(360, B_Y, 0);
    push(360, B_FS, 0); push(361, B_FS, 1);
    push(360, CB_VSLO, 48); push(360, CB_HSHI, 45); push(360, CB_RGB, 128); push(360, CB_FS, 1);
    push(720, CB_VSLO, 48); push(720, CB_FS, 1);
    repeat (1600) tick();

    // Pattern select with a colour unlike any checked bar.
    rgb_in = 3'b110; pattern_sel = 1'b1;
    do_reset(2, 1'b0);
    rst = 1'b1; pix_en = 1'b1; base = cyc;
    push(1,   A_RGB, PAT ? 0 : 6);
    push(80,  A_RGB, PAT ? 0 : 6);
    push(81,  A_RGB, PAT ? 1 : 6);
    push(241, A_RGB, PAT ? 3 : 6);
    push(561, A_RGB, PAT ? 7 : 6);
    push(640, A_RGB, PAT ? 7 : 6);
    push(641, A_RGB, 0);
    repeat (650) tick();

    // One tick in four: every period scales by 4, outputs hold between ticks.
    rgb_in = 3'b101; pattern_sel = 1'b0;
    do_reset(2, 1'b0);
    rst = 1'b1; base = cyc;
    push(0, S_CLR, 0);
    push(1, A_X, 1); push(1, A_FS, 1); push(4, A_X, 1); push(4, A_FS, 1);
    push(5, A_X, 2); push(5, A_FS, 0);
    push(2624, A_HS, 1); push(2625, A_HS, 0);
    push(3196, A_X, 799); push(3197, A_X, 0); push(3197, A_Y, 1);
    push(3200, CA_HSLO, 384); push(3200, CA_RGB, 2560); push(3200, CA_FS, 4);
    pix_en = 1'b1;
    for (int k = 2; k <= 3200; k++) begin
      tick();
      pix_en = ((k % 4) == 1);
    end
    tick();

    // Mid-frame reset for one cycle, then continuous ticks.
    do_reset(2, 1'b1);
    rst = 1'b1; pix_en = 1'b1; base = cyc;
    push(1500, A_X, 700); push(1500, A_Y, 1); push(1500, A_HS, 0);
    push(1500, B_X, 12);  push(1500, B_Y, 2); push(1500, B_VON, 1);
    push(1501, A_X, 0);   push(1501, A_Y, 0); push(1501, A_HS, 1); push(1501, A_VS, 1);
    push(1501, A_VON, 0); push(1501, A_RGB, 0); push(1501, A_FS, 0);
    push(1501, B_X, 0);   push(1501, B_Y, 0); push(1501, B_HS, 0); push(1501, B_VON, 0);
    push(1502, A_FS, 1);  push(1502, A_X, 1); push(1502, B_FS, 1);
    push(1503, A_FS, 0);
    repeat (1500) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (6) tick();

    while (sbq.size() > 0) begin
      me = sbq.pop_front();
      if (me.sel != S_CLR) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: expectation for cycle %0d never checked, required %0d",
                 me.sel.name(), me.cyc, me.val);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
